vector_mem_unit: RTL and testbench
==================================

# vector_mem_unit

Memory-stage access unit for the vector CPU. It consumes the EX/MEM outputs (`AddressM`, `WriteDataM`, `MemWriteM`, `MemtoRegM`) and returns the `R`-lane `ReadData` vector that is registered into MEM/WB. The backing data RAM is one byte wide with a one-cycle read latency, so the unit serializes each `R`-byte vector access into `R` byte accesses. It holds the pipeline through `StallM` until the access completes.

## Interface

Parameters:
- `I`, 32: address width from the datapath.
- `N`, 8: lane width; equals the RAM data width.
- `R`, 6: lanes per vector.
- `AW`, 16: RAM address width. `AddressM[I-1:AW]` is ignored.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `MemWriteM`, in, 1: vector store request.
- `MemtoRegM`, in, 1: vector load request.
- `AddressM`, in, `I`: base byte address.
- `WriteDataM`, in, `[R-1:0][N-1:0]`: store data; lane 0 goes to the lowest address.
- `ReadData`, out, `[R-1:0][N-1:0]`: last completed load, registered.
- `StallM`, out, 1: freeze the IF/ID/EX/MEM pipeline registers.
- `mem_addr`, out, `AW`: RAM byte address.
- `mem_we`, out, 1: RAM write enable.
- `mem_wdata`, out, `N`: RAM write data.
- `mem_rdata`, in, `N`: RAM read data, valid one cycle after `mem_addr`.

## Operation

- The FSM has four states: IDLE, ACCESS, WAIT, DONE.
- Registers:
  - `base_q` (`AW` bits): captured base address.
  - `wdata_q` (`R`×`N` bits): captured store data.
  - `is_wr_q`: operation type.
  - `idx_q` (3 bits): lane index.
  - `rd_q`: the `ReadData` register.
- IDLE:
  - A request is `MemWriteM | MemtoRegM`.
  - On a request, capture `base_q = AddressM[AW-1:0]`, `wdata_q = WriteDataM` and `is_wr_q = MemWriteM`. Set `idx_q = 0` and go to ACCESS.
  - If both requests are asserted, the store wins and no load is performed.
- ACCESS:
  - `mem_addr = base_q + idx_q`, modulo 2^AW (wraps, no error).
  - `mem_we = is_wr_q`.
  - `mem_wdata = wdata_q[idx_q]`.
  - `idx_q` increments every cycle.
  - After lane `R-1`: go to DONE for a store, or to WAIT for a load.
- Load capture: in every cycle after a load ACCESS cycle for lane k, `rd_q[k] <= mem_rdata`. Lanes 0..`R-2` are captured in ACCESS and lane `R-1` in WAIT.
- WAIT: `mem_we = 0`. Capture the last lane, then go to DONE.
- DONE: `StallM = 0` and `ReadData` is valid. The pipeline advances at this edge, then the FSM returns to IDLE.
  - DONE never accepts a request, even though the same request is still on the inputs.
  - A new request is first examined in the following IDLE cycle.
- Outside ACCESS:
  - `mem_we = 0`.
  - `mem_addr` and `mem_wdata` hold their last values; they are 0 after reset.
- `rd_q` changes only on load captures. Stores never alter `ReadData`.
- Reset: the low edge forces IDLE immediately.
  - `mem_we` drops to 0 at once.
  - `rd_q`, `idx_q`, `base_q`, `wdata_q` and `is_wr_q` all clear to 0.
  - A partially done store leaves already-written bytes in place; the remaining lanes are never written.

## Timing

- `StallM = (state == IDLE & request) | state == ACCESS | state == WAIT`. It is forced to 0 while `reset` is low.
- The IDLE term is combinational from the inputs. Every other output is decoded from registers only.
- Let cycle 0 be the IDLE cycle in which a request is seen.
- Store:
  - ACCESS occupies cycles 1..`R`.
  - DONE is cycle `R+1`.
  - `StallM` is high for `R+1` cycles (7 at `R=6`).
- Load:
  - ACCESS occupies cycles 1..`R`.
  - WAIT is cycle `R+1`.
  - DONE is cycle `R+2`.
  - `StallM` is high for `R+2` cycles (8). `ReadData` is valid from cycle `R+2` and holds until the next load.
- The minimum gap between back-to-back requests is one DONE cycle. The next request is seen at cycle `R+2` (store) or `R+3` (load).
- Reset values:
  - `ReadData = 0`.
  - `StallM = 0`.
  - `mem_addr = 0`.
  - `mem_we = 0`.
  - `mem_wdata = 0`.

## Test plan

- Store: `AddressM=0x0010`, `WriteDataM` lanes 0..5 = 0x11..0x66, `MemWriteM` pulse held by the stall.
  - RAM bytes 0x10..0x15 = 0x11..0x66.
  - `mem_we` is high for exactly 6 cycles and `StallM` for 7.
- Load after that store: `AddressM=0x0010`, `MemtoRegM=1`.
  - `StallM` is high for 8 cycles.
  - `ReadData` lanes 0..5 = 0x11..0x66 in DONE.
- Wrap-around: store at `AddressM=0x0001FFFD` (`AW=16`).
  - Writes land at 0xFFFD, 0xFFFE, 0xFFFF, 0x0000, 0x0001, 0x0002.
  - Upper address bits are ignored.
- Simultaneous request: `MemWriteM=MemtoRegM=1` at 0x0020, data 0xA0..0xA5.
  - The store is performed.
  - `ReadData` is unchanged from its previous value.
  - `StallM` is high for 7 cycles.
- Reset mid-store: assert `reset` low during the ACCESS cycle for lane 3 of a store to 0x0040 (old RAM contents 0xEE).
  - `mem_we` drops immediately and `StallM` goes to 0.
  - Bytes 0x40..0x42 are updated; 0x43..0x45 are still 0xEE.
  - `ReadData = 0` and the FSM is in IDLE.
- Back-to-back: a store immediately followed by a load to the same address.
  - The load is first seen in the IDLE cycle after DONE.
  - `ReadData` returns the stored bytes.

Source files
------------

// File: rtl/vector_mem_unit.sv
// vector_mem_unit: memory-stage unit that serializes R-lane vector loads and
// stores onto a byte-wide RAM with one-cycle read latency, stalling the pipeline.
module vector_mem_unit #(
    parameter int I  = 32,
    parameter int N  = 8,
    parameter int R  = 6,
    parameter int AW = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MemWriteM,
    input  logic                MemtoRegM,
    input  logic [I-1:0]        AddressM,
    input  logic [R-1:0][N-1:0] WriteDataM,
    output logic [R-1:0][N-1:0] ReadData,
    output logic                StallM,
    output logic [AW-1:0]       mem_addr,
    output logic                mem_we,
    output logic [N-1:0]        mem_wdata,
    input  logic [N-1:0]        mem_rdata
);

    localparam logic [2:0] LAST = 3'(R - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [AW-1:0]         base_q;
    logic [R-1:0][N-1:0]   wdata_q;
    logic                  is_wr_q;
    logic [2:0]            idx_q;
    logic [R-1:0][N-1:0]   rd_q;
    logic [AW-1:0]         addr_q;
    logic [N-1:0]          wbyte_q;

    logic                  request;
    logic [AW-1:0]         cur_addr;
    logic [N-1:0]          cur_wdata;
    logic                  addr_hi_unused;

    assign request        = MemWriteM | MemtoRegM;
    assign cur_addr       = base_q + AW'(idx_q);
    assign cur_wdata      = wdata_q[idx_q];
    assign addr_hi_unused = ^AddressM[I-1:AW];
    assign ReadData       = rd_q;

    always_comb begin
        state_d   = state_q;
        StallM    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wbyte_q;
        unique case (state_q)
            IDLE: begin
                StallM = request;
                if (request) state_d = ACCESS;
            end
            ACCESS: begin
                StallM    = 1'b1;
                mem_we    = is_wr_q;
                mem_addr  = cur_addr;
                mem_wdata = cur_wdata;
                if (idx_q == LAST) state_d = is_wr_q ? DONE : WAIT;
            end
            WAIT: begin
                StallM  = 1'b1;
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!reset) StallM = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            idx_q   <= '0;
            rd_q    <= '0;
            addr_q  <= '0;
            wbyte_q <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (request) begin
                        base_q  <= AddressM[AW-1:0];
                        wdata_q <= WriteDataM;
                        is_wr_q <= MemWriteM;
                        idx_q   <= '0;
                    end
                end
                ACCESS: begin
                    idx_q   <= idx_q + 3'd1;
                    addr_q  <= cur_addr;
                    wbyte_q <= cur_wdata;
                    // RAM data returned now belongs to the previous lane
                    if (!is_wr_q && idx_q != 3'd0)
                        rd_q[idx_q - 3'd1] <= mem_rdata;
                end
                WAIT: rd_q[LAST] <= mem_rdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_mem_unit.sv
// tb_vector_mem_unit: randomized scoreboard bench for vector_mem_unit with a
// byte RAM model and a reference memory image kept at transaction level.
module tb_vector_mem_unit;

    localparam int R = 6;

    typedef logic [R-1:0][7:0] vec_t;
    typedef struct {
        int   stall;
        int   nwe;
        vec_t rd;
    } exp_t;
    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWriteM = 1'b0;
    logic        MemtoRegM = 1'b0;
    logic [31:0] AddressM = '0;
    vec_t        WriteDataM = '0;
    vec_t        ReadData;
    logic        StallM;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;

    vector_mem_unit dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .MemtoRegM  (MemtoRegM),
        .AddressM   (AddressM),
        .WriteDataM (WriteDataM),
        .ReadData   (ReadData),
        .StallM     (StallM),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [7:0] ram     [0:65535];
    logic [7:0] ref_ram [0:65535];
    vec_t       model_rd;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int   compared = 0;
    int   mismatched = 0;
    exp_t eq[$];
    wr_t  wq[$];
    bit   mon_en = 1'b0;
    int   stall_cnt = 0;
    int   we_cnt = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: pops expected writes and transaction results as the DUT shows them
    always @(negedge clk) begin : monitor
        wr_t  w;
        exp_t e;
        if (!mon_en) begin
            stall_cnt = 0;
            we_cnt    = 0;
        end else begin
            if (mem_we) begin
                we_cnt++;
                if (wq.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_write: addr %0h data %0h",
                             mem_addr, mem_wdata);
                end else begin
                    w = wq.pop_front();
                    check("wr_addr", 64'(mem_addr), 64'(w.a));
                    check("wr_data", 64'(mem_wdata), 64'(w.d));
                end
            end
            if (StallM) begin
                stall_cnt++;
            end else if (stall_cnt > 0) begin
                if (eq.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_done: stall %0d", stall_cnt);
                end else begin
                    e = eq.pop_front();
                    check("stall_len", 64'(stall_cnt), 64'(e.stall));
                    check("we_count", 64'(we_cnt), 64'(e.nwe));
                    check("read_data", 64'(ReadData), 64'(e.rd));
                end
                stall_cnt = 0;
                we_cnt    = 0;
            end
        end
    end

    // called at posedge+1 with the DUT idle; returns at posedge+1 after DONE
    task automatic issue(bit wr, bit rd, logic [31:0] addr, vec_t data);
        exp_t        e;
        int          n;
        logic [15:0] b;
        b     = addr[15:0];
        e.nwe = 0;
        if (wr) begin
            for (int k = 0; k < R; k++) begin
                wq.push_back('{b + 16'(k), data[k]});
                ref_ram[b + 16'(k)] = data[k];
            end
            e.stall = R + 1;
            e.nwe   = R;
        end else begin
            for (int k = 0; k < R; k++)
                model_rd[k] = ref_ram[b + 16'(k)];
            e.stall = R + 2;
        end
        e.rd = model_rd;
        eq.push_back(e);
        MemWriteM  = wr;
        MemtoRegM  = rd;
        AddressM   = addr;
        WriteDataM = data;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (StallM && n < 20);
        if (StallM) begin
            compared++;
            mismatched++;
            $display("FAIL timeout: stall still high after %0d cycles", n);
        end
        @(posedge clk);
        #1;
        MemWriteM = 1'b0;
        MemtoRegM = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vec_t        d;
        logic [31:0] a;
        int          op;
        int          diffs;
        for (int i = 0; i < 65536; i++) begin
            ram[i]     = 8'h00;
            ref_ram[i] = 8'h00;
        end
        model_rd = '0;

        #12;
        check("rst_readdata", 64'(ReadData), 64'd0);
        check("rst_stall", 64'(StallM), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        for (int k = 0; k < R; k++) d[k] = 8'(8'h11 * (k + 1));
        issue(1'b1, 1'b0, 32'h0000_0010, d);
        issue(1'b0, 1'b1, 32'h0000_0010, '0);
        check("load_0x10", 64'(ReadData), 64'h6655_4433_2211);

        for (int k = 0; k < R; k++) d[k] = 8'($urandom);
        issue(1'b1, 1'b0, 32'h0001_FFFD, d);
        issue(1'b0, 1'b1, 32'hABCD_FFFD, '0);
        idle(2);

        for (int k = 0; k < R; k++) d[k] = 8'(8'hA0 + k);
        issue(1'b1, 1'b1, 32'h0000_0020, d);
        issue(1'b0, 1'b1, 32'h0000_0020, '0);

        for (int k = 0; k < R; k++) d[k] = 8'hEE;
        issue(1'b1, 1'b0, 32'h0000_0040, d);
        mon_en = 1'b0;
        for (int k = 0; k < R; k++) d[k] = 8'(8'h50 + k);
        MemWriteM  = 1'b1;
        AddressM   = 32'h0000_0040;
        WriteDataM = d;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_we", 64'(mem_we), 64'd0);
        check("rst_mid_stall", 64'(StallM), 64'd0);
        MemWriteM = 1'b0;
        @(negedge clk);
        check("rst_mid_rd", 64'(ReadData), 64'd0);
        check("rst_mid_addr", 64'(mem_addr), 64'd0);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) ref_ram[16'h40 + 16'(k)] = d[k];
        model_rd = '0;
        @(posedge clk);
        #1;
        check("rst_byte42", 64'(ram[16'h42]), 64'h52);
        check("rst_byte43", 64'(ram[16'h43]), 64'hEE);
        check("rst_byte45", 64'(ram[16'h45]), 64'hEE);
        mon_en = 1'b1;
        issue(1'b0, 1'b1, 32'h0000_0040, '0);

        for (int t = 0; t < 40; t++) begin
            a = $urandom();
            if ($urandom_range(0, 3) == 0)
                a[15:0] = 16'hFFFA + 16'($urandom_range(0, 5));
            else
                a[15:0] = 16'($urandom_range(0, 63));
            for (int k = 0; k < R; k++) d[k] = 8'($urandom);
            op = $urandom_range(0, 2);
            issue(op != 1, op != 0, a, d);
            idle($urandom_range(0, 2));
        end

        diffs = 0;
        for (int i = 0; i < 65536; i++)
            if (ram[i] !== ref_ram[i]) diffs++;
        check("ram_image", 64'(diffs), 64'd0);
        check("queues_drained", 64'(eq.size() + wq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
